// File: rtl/led_blink_frequency_decoder.sv
// Recovers the 2-bit blink-rate code from a looped-back LED waveform by timing
// its half-periods and locking once several consecutive ones land in the same class.
module led_blink_frequency_decoder #(
    parameter int unsigned c_CNT_100Hz   = 125,
    parameter int unsigned c_CNT_50Hz    = 250,
    parameter int unsigned c_CNT_10Hz    = 1250,
    parameter int unsigned c_CNT_1Hz     = 12500,
    parameter int unsigned c_TOL         = 4,
    parameter int unsigned c_MATCH_COUNT = 3,
    parameter int unsigned c_TIMEOUT     = 25000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_blink,
    output logic [1:0] o_switch_code,
    output logic       o_valid,
    output logic       o_error,
    output logic       o_stuck
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [31:0] CNT_MAX   = 32'(c_TIMEOUT - 1);
    localparam logic [7:0]  MATCH_REQ = 8'(c_MATCH_COUNT);

    state_t      state;
    state_t      state_next;
    logic        sync_p0;
    logic        sync_p1;
    logic        blink_p2;
    logic        blink_edge;
    logic [31:0] cnt;
    logic [31:0] measured;
    logic        timeout_hit;
    logic        hit;
    logic [1:0]  cls;
    logic [1:0]  r_class;
    logic [7:0]  r_match;
    logic [7:0]  match_inc;
    logic [1:0]  class_next;
    logic [7:0]  match_next;
    logic [1:0]  code_next;
    logic        valid_next;
    logic        error_next;
    logic        stuck_next;

    // Window test on the measured value only; the nominal side carries the tolerance.
    function automatic logic in_window(input logic [31:0] m, input logic [31:0] nom);
        return (m >= (nom - c_TOL)) && (m <= (nom + c_TOL));
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: previous synchronised level for edge detect
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            blink_p2 <= 1'b0;
        end else begin
            sync_p0  <= i_blink;
            sync_p1  <= sync_p0;
            blink_p2 <= sync_p1;
        end
    end

    assign blink_edge = sync_p1 ^ blink_p2;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt <= 32'd0;
        end else if (blink_edge) begin
            cnt <= 32'd0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign measured    = cnt + 32'd1;
    assign timeout_hit = !blink_edge && (cnt >= CNT_MAX);

    always_comb begin
        hit = 1'b1;
        cls = 2'd0;
        if (in_window(measured, 32'(c_CNT_100Hz))) begin
            cls = 2'd0;
        end else if (in_window(measured, 32'(c_CNT_50Hz))) begin
            cls = 2'd1;
        end else if (in_window(measured, 32'(c_CNT_10Hz))) begin
            cls = 2'd2;
        end else if (in_window(measured, 32'(c_CNT_1Hz))) begin
            cls = 2'd3;
        end else begin
            hit = 1'b0;
        end
    end

    // A run restarts at 1 when the class changes mid-track; a zero run always extends.
    assign match_inc = ((r_match == 8'd0) || (cls == r_class)) ? r_match + 8'd1 : 8'd1;

    always_comb begin
        state_next = state;
        class_next = r_class;
        match_next = r_match;
        code_next  = o_switch_code;
        valid_next = o_valid;
        error_next = 1'b0;
        stuck_next = o_stuck;
        if (blink_edge) begin
            stuck_next = 1'b0;
            case (state)
                IDLE: begin
                    state_next = TRACK;
                    match_next = 8'd0;
                end
                TRACK: begin
                    if (!hit) begin
                        match_next = 8'd0;
                        error_next = 1'b1;
                    end else begin
                        match_next = match_inc;
                        class_next = cls;
                        if (match_inc >= MATCH_REQ) begin
                            state_next = LOCKED;
                            valid_next = 1'b1;
                            code_next  = cls;
                        end
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        state_next = TRACK;
                        match_next = 8'd0;
                        valid_next = 1'b0;
                        error_next = 1'b1;
                    end else if (cls != r_class) begin
                        state_next = TRACK;
                        class_next = cls;
                        match_next = 8'd1;
                        valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    match_next = 8'd0;
                    valid_next = 1'b0;
                end
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
            valid_next = 1'b0;
            stuck_next = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            r_class       <= 2'd0;
            r_match       <= 8'd0;
            o_switch_code <= 2'd0;
            o_valid       <= 1'b0;
            o_error       <= 1'b0;
            o_stuck       <= 1'b0;
        end else begin
            state         <= state_next;
            r_class       <= class_next;
            r_match       <= match_next;
            o_switch_code <= code_next;
            o_valid       <= valid_next;
            o_error       <= error_next;
            o_stuck       <= stuck_next;
        end
    end

endmodule

// File: tb/tb_led_blink_frequency_decoder.sv
// Bench for led_blink_frequency_decoder: directed scenarios plus randomized half-periods,
// every cycle compared against a timestamp-based reference model.
module tb_led_blink_frequency_decoder;

    localparam int TOL     = 4;
    localparam int TIMEOUT = 25000;
    localparam int NEED    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       blink;
    logic [1:0] code;
    logic       valid;
    logic       error;
    logic       stuck;

    always #5 clk = ~clk;

    led_blink_frequency_decoder dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_blink       (blink),
        .o_switch_code (code),
        .o_valid       (valid),
        .o_error       (error),
        .o_stuck       (stuck)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: time stamps of detected edges instead of counters.
    int nom [4] = '{125, 250, 1250, 12500};
    int n_cyc   = 0;
    int last_edge = 0;
    bit hist [3];
    int m_phase;   // 0 waiting for first edge, 1 tracking, 2 locked
    int m_class, m_run, m_code, m_valid, m_error, m_stuck;

    int err_seen    = 0;
    int novalid_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n_cyc);
        end
    endtask

    function automatic int classify(input int m);
        for (int k = 0; k < 4; k++) begin
            if (m - nom[k] <= TOL && nom[k] - m <= TOL) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit b);
        bit ed;
        int m;
        int k;
        n_cyc++;
        if (r) begin
            m_phase = 0; m_class = 0; m_run = 0;
            m_code = 0; m_valid = 0; m_error = 0; m_stuck = 0;
            hist = '{1'b0, 1'b0, 1'b0};
            last_edge = n_cyc;
            return;
        end
        // The level seen two cycles ago differs from the one three cycles ago.
        ed = hist[1] != hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = b;
        m_error = 0;
        if (ed) begin
            m = n_cyc - last_edge;
            if (m > TIMEOUT) m = TIMEOUT;
            last_edge = n_cyc;
            k = classify(m);
            m_stuck = 0;
            if (m_phase == 0) begin
                m_phase = 1;
                m_run = 0;
            end else if (m_phase == 1) begin
                if (k < 0) begin
                    m_run = 0;
                    m_error = 1;
                end else begin
                    m_run = (m_run == 0 || k == m_class) ? m_run + 1 : 1;
                    m_class = k;
                    if (m_run >= NEED) begin
                        m_phase = 2;
                        m_valid = 1;
                        m_code = k;
                    end
                end
            end else begin
                if (k < 0) begin
                    m_phase = 1; m_run = 0; m_valid = 0; m_error = 1;
                end else if (k != m_class) begin
                    m_phase = 1; m_class = k; m_run = 1; m_valid = 0;
                end
            end
        end else if (n_cyc - last_edge >= TIMEOUT) begin
            m_phase = 0;
            m_valid = 0;
            m_stuck = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, blink);
        #1;
        check("code",  32'(code),  32'(m_code));
        check("valid", 32'(valid), 32'(m_valid));
        check("error", 32'(error), 32'(m_error));
        check("stuck", 32'(stuck), 32'(m_stuck));
        if (error === 1'b1) err_seen++;
        if (valid !== 1'b1) novalid_seen++;
    endtask

    task automatic half(input int hp);
        blink = ~blink;
        repeat (hp) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blink = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int e0, v0, hp, reps, mode, cl;

    initial begin
        rst = 1'b1;
        blink = 1'b0;
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stuck", 32'(stuck), 32'd0);
        do_reset();

        // 100Hz lock after four edges, no errors
        e0 = err_seen;
        repeat (4) half(125);
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_code", 32'(code), 32'd0);
        check("t1_errors", 32'(err_seen - e0), 32'd0);

        // Switch from 100Hz to 1Hz
        half(12500);
        check("t2_still_locked", 32'(valid), 32'd1);
        half(12500);
        check("t2_dropped", 32'(valid), 32'd0);
        half(12500);
        check("t2_not_yet", 32'(valid), 32'd0);
        half(10);
        check("t2_relock", 32'(valid), 32'd1);
        check("t2_code", 32'(code), 32'd3);

        // Window boundaries
        do_reset();
        repeat (4) half(129);
        check("t3_129_valid", 32'(valid), 32'd1);
        check("t3_129_code", 32'(code), 32'd0);
        do_reset();
        e0 = err_seen; v0 = novalid_seen;
        repeat (5) half(130);
        check("t3_130_errors", 32'(err_seen - e0), 32'd4);
        check("t3_130_novalid", 32'(novalid_seen - v0), 32'(5 * 130));
        do_reset();
        repeat (4) half(121);
        check("t3_121_valid", 32'(valid), 32'd1);
        do_reset();
        e0 = err_seen; v0 = novalid_seen;
        repeat (5) half(120);
        check("t3_120_errors", 32'(err_seen - e0), 32'd4);
        check("t3_120_novalid", 32'(novalid_seen - v0), 32'(5 * 120));

        // Stuck input after a 10Hz lock
        do_reset();
        repeat (4) half(1250);
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_code", 32'(code), 32'd2);
        repeat (25010) tick();
        check("t4_stuck", 32'(stuck), 32'd1);
        check("t4_novalid", 32'(valid), 32'd0);
        half(5);
        check("t4_unstuck", 32'(stuck), 32'd0);

        // Reset while locked at 50Hz
        do_reset();
        repeat (4) half(250);
        check("t5_valid", 32'(valid), 32'd1);
        check("t5_code", 32'(code), 32'd1);
        rst = 1'b1;
        blink = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_code", 32'(code), 32'd0);
        repeat (3) half(250);
        check("t5_three_edges", 32'(valid), 32'd0);
        half(250);
        check("t5_relock", 32'(valid), 32'd1);
        check("t5_relock_code", 32'(code), 32'd1);

        // One-clock glitch while locked at 100Hz
        do_reset();
        repeat (4) half(125);
        half(60);
        e0 = err_seen; v0 = novalid_seen;
        half(1);
        half(64);
        check("t6_dropped", 32'(novalid_seen - v0 > 0), 32'd1);
        repeat (4) half(125);
        check("t6_errors", 32'(err_seen - e0), 32'd3);
        check("t6_relock", 32'(valid), 32'd1);
        check("t6_code", 32'(code), 32'd0);

        // Randomized half-periods around and outside the two fastest classes
        do_reset();
        repeat (25) begin
            cl   = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 5));
            reps = int'($urandom_range(1, 4));
            if (mode == 0) begin
                hp = nom[cl] + int'($urandom_range(5, 12));
            end else if (mode == 1) begin
                hp = nom[cl] - int'($urandom_range(5, 12));
            end else if (mode == 2) begin
                hp = int'($urandom_range(1, 3));
            end else begin
                hp = nom[cl] + int'($urandom_range(0, 2 * TOL)) - TOL;
            end
            repeat (reps) half(hp);
        end
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
